// File: rtl/fmap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fmap_pkg
// Brief    : Shared types and helpers for the feature-map window buffer.
// Revision : 1.0
// ============================================================================
package fmap_pkg;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FULL = 2'd1,
        S_RD   = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [1:0] TAP_TL = 2'd0;
    localparam logic [1:0] TAP_TR = 2'd1;
    localparam logic [1:0] TAP_BL = 2'd2;
    localparam logic [1:0] TAP_BR = 2'd3;

    // Number of 2-wide window positions along one axis; a trailing partial step is dropped.
    function automatic int win_count(input int dim, input int stride);
        return (dim - 2) / stride + 1;
    endfunction

    function automatic int tap_offset(input logic [1:0] tap, input int map_w);
        case (tap)
            TAP_TL:  return 0;
            TAP_TR:  return 1;
            TAP_BL:  return map_w;
            default: return map_w + 1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_ram.sv
`default_nettype none
// ============================================================================
// Module   : fmap_ram
// Brief    : Simple dual-port RAM, one write port, registered read port.
// Revision : 1.0
// ============================================================================
module fmap_ram #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 676,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fmap_win_buf.sv
`default_nettype none
// ============================================================================
// Module   : fmap_win_buf
// Brief    : Stores one raster-written feature map, then streams 2x2 windows.
// Revision : 1.0
// ============================================================================
module fmap_win_buf
    import fmap_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int MAP_W  = 26,
    parameter int MAP_H  = 26,
    parameter int STRIDE = 2,
    localparam int AW    = $clog2(MAP_W * MAP_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_start,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [DATA_W-1:0] win_tap0,
    output logic [DATA_W-1:0] win_tap1,
    output logic [DATA_W-1:0] win_tap2,
    output logic [DATA_W-1:0] win_tap3,
    output logic              win_last,
    output logic              done
);

    localparam int DEPTH = MAP_W * MAP_H;
    localparam int CW    = $clog2(MAP_W);
    localparam int RW    = $clog2(MAP_H);
    localparam int NX    = win_count(MAP_W, STRIDE);
    localparam int NY    = win_count(MAP_H, STRIDE);

    localparam logic [CW-1:0] LAST_C    = CW'((NX - 1) * STRIDE);
    localparam logic [RW-1:0] LAST_R    = RW'((NY - 1) * STRIDE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(STRIDE * MAP_W);

    state_t            state_q, state_d;
    logic [1:0]        ph_q, ph_d;
    logic [CW-1:0]     c_q, c_d;
    logic [RW-1:0]     r_q, r_d;
    logic [AW-1:0]     rb_q, rb_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic              done_q, done_d;
    logic              wr_ready_q, wr_ready_d;
    logic [DATA_W-1:0] taps_q [4];

    logic              wr_fire;
    logic              at_last;
    logic              col_wrap;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign wr_fire  = wr_valid && wr_ready_q;
    assign at_last  = (r_q == LAST_R) && (c_q == LAST_C);
    assign col_wrap = (32'(c_q) + 32'(STRIDE)) > 32'(MAP_W - 2);

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        c_d       = c_q;
        r_d       = r_q;
        rb_d      = rb_q;
        wr_addr_d = wr_addr_q;
        done_d    = 1'b0;

        case (state_q)
            S_FILL: begin
                if (wr_fire) begin
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d   = S_FULL;
                        wr_addr_d = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            S_FULL: begin
                if (rd_start) begin
                    state_d = S_RD;
                    ph_d    = '0;
                end
            end
            S_RD: begin
                ph_d = ph_q + 2'd1;
                if (ph_q == TAP_BR) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (win_ready) begin
                    if (at_last) begin
                        state_d   = S_FILL;
                        c_d       = '0;
                        r_d       = '0;
                        rb_d      = '0;
                        wr_addr_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = S_RD;
                        if (col_wrap) begin
                            c_d  = '0;
                            r_d  = r_q + RW'(STRIDE);
                            rb_d = rb_q + ROW_STEP;
                        end else begin
                            c_d = c_q + CW'(STRIDE);
                        end
                    end
                end
            end
            default: state_d = S_FILL;
        endcase

        if (clr) begin
            state_d   = S_FILL;
            ph_d      = '0;
            c_d       = '0;
            r_d       = '0;
            rb_d      = '0;
            wr_addr_d = '0;
            done_d    = 1'b0;
        end

        wr_ready_d = (state_d == S_FILL);

        // The top-left read is issued on the transition cycle so the window is ready 5 cycles later.
        if ((state_q == S_RD) && (ph_q != TAP_BR)) begin
            rd_addr = rb_q + AW'(c_q) + AW'(tap_offset(ph_q + 2'd1, MAP_W));
        end else begin
            rd_addr = rb_d + AW'(c_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FILL;
            ph_q       <= '0;
            c_q        <= '0;
            r_q        <= '0;
            rb_q       <= '0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            c_q        <= c_d;
            r_q        <= r_d;
            rb_q       <= rb_d;
            wr_addr_q  <= wr_addr_d;
            done_q     <= done_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_q <= '{default: '0};
        end else if (state_q == S_RD) begin
            taps_q[ph_q] <= rd_data;
        end
    end

    fmap_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_fire && !clr),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign wr_ready  = wr_ready_q;
    assign full      = (state_q != S_FILL);
    assign win_valid = (state_q == S_OUT);
    assign win_last  = (state_q == S_OUT) && at_last;
    assign done      = done_q;
    assign win_tap0  = taps_q[TAP_TL];
    assign win_tap1  = taps_q[TAP_TR];
    assign win_tap2  = taps_q[TAP_BL];
    assign win_tap3  = taps_q[TAP_BR];

endmodule
`default_nettype wire

// File: doc/fmap_win_buf.md
Name: fmap_win_buf

Overview:
Parametrised feature-map buffer for the CNN datapath: stores one MAP_W x MAP_H map of DATA_W-bit activations written in raster order, then scans it and emits 2x2 windows (four taps in parallel) for the pooling/next-layer stage.
Adds auto-addressed streaming write, a full/scan state machine, a configurable window stride and a valid/ready output handshake over a single-read-port RAM.

Parameters:
DATA_W, 18, activation width in bits
MAP_W, 26, map width in pixels (>=2)
MAP_H, 26, map height in pixels (>=2)
STRIDE, 2, window step in both x and y (1 or 2)
AW, $clog2(MAP_W*MAP_H), RAM address width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous abort: return to S_FILL, counters zeroed
wr_valid  in  1  input pixel valid
wr_ready  out  1  buffer accepts a pixel (high only in S_FILL)
wr_data  in  DATA_W  input pixel, raster order, row 0 col 0 first
full  out  1  complete map stored, scan may start
rd_start  in  1  single-cycle request to begin a window scan
win_valid  out  1  win_tap0..3 hold a valid window
win_ready  in  1  consumer accepts window
win_tap0..win_tap3  out  DATA_W each  taps (r,c), (r,c+1), (r+1,c), (r+1,c+1)
win_last  out  1  qualifies the final window of the scan
done  out  1  one-cycle pulse after final window is accepted

Behaviour:
- Reset values: wr_ready=0 during reset, 1 from the first cycle after release; full=0, win_valid=0, win_last=0, done=0, taps=0, all counters 0, state S_FILL. RAM contents are not cleared.
- RAM: MAP_W*MAP_H x DATA_W, one write port, one synchronous read port, 1-cycle read latency.
- S_FILL: wr_ready=1. On wr_valid&wr_ready, write wr_data at wr_addr, then increment wr_addr. On the write at address MAP_W*MAP_H-1, go to S_FULL next cycle. full=1 from that cycle on.
- S_FULL: wr_ready=0, full=1. rd_start moves to S_RD. rd_start in any other state is ignored.
- S_RD: issue four reads on consecutive cycles:
  - tap0 at base=r*MAP_W+c
  - tap1 at base+1
  - tap2 at base+MAP_W
  - tap3 at base+MAP_W+1
  - Each tap register loads on the cycle after its read is issued.
  - Then go to S_OUT. win_valid rises exactly 5 cycles after rd_start, or after the preceding win handshake.
- S_OUT: win_valid=1. Taps and win_last stay stable until win_valid&win_ready.
  - On the handshake, advance c+=STRIDE. When c+STRIDE > MAP_W-2, set c=0 and r+=STRIDE.
  - If the accepted window was the last one, pulse done and go to S_FILL. wr_addr=0 and full=0, so the buffer refills.
  - Otherwise return to S_RD.
- Window count: NX=(MAP_W-2)/STRIDE+1, NY=(MAP_H-2)/STRIDE+1, integer floor. Trailing odd row/column is dropped.
  - win_last=1 when r=(NY-1)*STRIDE and c=(NX-1)*STRIDE.
- Address arithmetic uses AW bits. base+MAP_W+1 never exceeds MAP_W*MAP_H-1, so no wrap is permitted or needed.
- Simultaneous events:
  - clr has priority over every transition. It aborts a scan, drops win_valid, suppresses done and returns to S_FILL.
  - A write and rd_start cannot overlap, because wr_ready=0 outside S_FILL.
- Async reset mid-scan: immediate return to reset values. The next map must be rewritten from address 0.

Decomposition:
- Package fmap_pkg:
  - state enum {S_FILL,S_FULL,S_RD,S_OUT}
  - tap index constants TAP_TL/TR/BL/BR
  - function for window count
- One sub-module fmap_ram (simple dual-port, parametrised DATA_W/depth, registered read, no reset on storage).
- FSM, counters and tap registers stay in the top.

Test Plan:
- MAP_W=4, MAP_H=4, STRIDE=2; write 0..15 with win_ready=1.
  - Expect 4 windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}.
  - Expect win_last on the 4th window and done one cycle after it.
- Same data, STRIDE=1.
  - Expect 9 windows, first {0,1,4,5}, fifth {5,6,9,10}, last {10,11,14,15}.
- MAP_W=5, MAP_H=5, STRIDE=2; data 0..24.
  - Expect 4 windows, last {12,13,17,18}. Column and row 4 are never read.
- Backpressure: hold win_ready=0 for 10 cycles on window 2.
  - win_valid stays 1 and the taps stay {2,3,6,7} throughout.
  - The next window arrives 5 cycles after release.
- Write attempt while full: wr_valid=1 with data 0xFFFF in S_FULL. wr_ready=0 and the scan output is unchanged. rd_start in S_FILL produces no window.
- Reset and clr mid-scan:
  - Assert rst_n=0 during window 2. All outputs drop to 0 asynchronously.
  - After refill with 100..115, the first window is {100,101,104,105}.
  - Repeat with clr: same result, no done pulse.
